// File: rtl/act_lut_loader.sv
// act_lut_loader: runtime-programmable activation lookup table.
// A configuration stream fills the table in address order (LOAD); the block
// then serves a valid/ready lookup stream with one registered output stage
// (RUN). A reload request drains any pending output (DRAIN) before the table
// may be rewritten.
module act_lut_loader #(
    parameter int DATA_IN_WIDTH  = 6,
    parameter int DATA_OUT_WIDTH = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    // configuration stream
    input  logic [DATA_OUT_WIDTH-1:0] cfg_data,
    input  logic                      cfg_last,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    output logic                      cfg_error,
    // control / status
    input  logic                      reload,
    output logic                      table_loaded,
    // lookup request
    input  logic [DATA_IN_WIDTH-1:0]  data_in_0,
    input  logic                      data_in_0_valid,
    output logic                      data_in_0_ready,
    // lookup result
    output logic [DATA_OUT_WIDTH-1:0] data_out_0,
    output logic                      data_out_0_valid,
    input  logic                      data_out_0_ready
);

    localparam int DEPTH = 2 ** DATA_IN_WIDTH;

    // Highest table address; the beat written here must carry cfg_last.
    localparam logic [DATA_IN_WIDTH-1:0] LAST_ADDR = {DATA_IN_WIDTH{1'b1}};
    localparam logic [DATA_IN_WIDTH-1:0] PTR_ONE   = {{(DATA_IN_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic [DATA_IN_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
    logic                      cfg_error_q, cfg_error_d;
    logic [DATA_OUT_WIDTH-1:0] dout_q, dout_d;
    logic                      dout_vld_q, dout_vld_d;

    logic [DATA_OUT_WIDTH-1:0] table_q [DEPTH];

    logic cfg_fire;
    logic lut_fire;
    logic out_fire;
    logic last_slot;

    // Handshake qualifiers. cfg_ready is held low while rst is asserted so no
    // beat can be taken in the reset cycle; a reload cycle never accepts a
    // lookup so the pending-output decision below stays simple.
    assign cfg_ready       = (state_q == S_LOAD) && !rst;
    assign data_in_0_ready = (state_q == S_RUN) && !reload && !rst &&
                             (!dout_vld_q || data_out_0_ready);

    assign cfg_fire  = cfg_valid && cfg_ready;
    assign lut_fire  = data_in_0_valid && data_in_0_ready;
    assign out_fire  = dout_vld_q && data_out_0_ready;
    assign last_slot = (wr_ptr_q == LAST_ADDR);

    assign table_loaded     = (state_q == S_RUN);
    assign cfg_error        = cfg_error_q;
    assign data_out_0       = dout_q;
    assign data_out_0_valid = dout_vld_q;

    // Next-state logic: load sequencing, lookup output stage and reload drain.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        cfg_error_d = cfg_error_q;
        dout_d      = dout_q;
        dout_vld_d  = dout_vld_q;

        unique case (state_q)
            S_LOAD: begin
                if (cfg_fire) begin
                    if (last_slot && cfg_last) begin
                        // Complete, well-framed load.
                        state_d  = S_RUN;
                        wr_ptr_d = '0;
                    end else if (last_slot || cfg_last) begin
                        // Early or missing cfg_last: the entry is still
                        // written, but the table is unusable until a
                        // full clean load starts again from address 0.
                        cfg_error_d = 1'b1;
                        wr_ptr_d    = '0;
                    end else begin
                        wr_ptr_d = wr_ptr_q + PTR_ONE;
                    end
                end
            end

            S_RUN: begin
                if (lut_fire) begin
                    dout_d     = table_q[data_in_0];
                    dout_vld_d = 1'b1;
                end else if (out_fire) begin
                    dout_vld_d = 1'b0;
                end

                if (reload) begin
                    // With no output left behind after this edge the table
                    // can be rewritten at once; otherwise wait for the
                    // consumer to take the pending result.
                    if (!dout_vld_q || out_fire) begin
                        state_d = S_LOAD;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end
            end

            S_DRAIN: begin
                if (out_fire) begin
                    dout_vld_d = 1'b0;
                    state_d    = S_LOAD;
                end
            end

            default: begin
                state_d = S_LOAD;
            end
        endcase
    end

    // Control and output-stage registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_LOAD;
            wr_ptr_q    <= '0;
            cfg_error_q <= 1'b0;
            dout_q      <= '0;
            dout_vld_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            cfg_error_q <= cfg_error_d;
            dout_q      <= dout_d;
            dout_vld_q  <= dout_vld_d;
        end
    end

    // Table storage: cleared on reset, written only by accepted config beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                table_q[i] <= '0;
            end
        end else if (cfg_fire) begin
            table_q[wr_ptr_q] <= cfg_data;
        end
    end

endmodule

// File: tb/tb_act_lut_loader.sv
// Testbench for act_lut_loader: scenario tasks with a behavioural table model.
module tb_act_lut_loader;

    localparam int AW    = 6;
    localparam int DW    = 6;
    localparam int DEPTH = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] cfg_data;
    logic          cfg_last;
    logic          cfg_valid;
    logic          cfg_ready;
    logic          cfg_error;
    logic          reload;
    logic          table_loaded;
    logic [AW-1:0] data_in_0;
    logic          data_in_0_valid;
    logic          data_in_0_ready;
    logic [DW-1:0] data_out_0;
    logic          data_out_0_valid;
    logic          data_out_0_ready;

    int checks = 0;
    int errors = 0;

    // Model: what the table should hold, and where the next config beat lands.
    logic [DW-1:0] model_tab [DEPTH];
    logic [DW-1:0] next_tab  [DEPTH];
    int            mptr;
    bit            merr;
    bit            exp_vld;
    logic [DW-1:0] exp_data;

    always #5 clk = ~clk;

    act_lut_loader #(
        .DATA_IN_WIDTH (AW),
        .DATA_OUT_WIDTH(DW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .cfg_data        (cfg_data),
        .cfg_last        (cfg_last),
        .cfg_valid       (cfg_valid),
        .cfg_ready       (cfg_ready),
        .cfg_error       (cfg_error),
        .reload          (reload),
        .table_loaded    (table_loaded),
        .data_in_0       (data_in_0),
        .data_in_0_valid (data_in_0_valid),
        .data_in_0_ready (data_in_0_ready),
        .data_out_0      (data_out_0),
        .data_out_0_valid(data_out_0_valid),
        .data_out_0_ready(data_out_0_ready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) model_tab[i] = '0;
        mptr     = 0;
        merr     = 1'b0;
        exp_vld  = 1'b0;
        exp_data = '0;
    endtask

    task automatic fill_next_random();
        for (int i = 0; i < DEPTH; i++) next_tab[i] = DW'($urandom);
    endtask

    // One accepted config beat (DUT is in LOAD), optionally preceded by an
    // idle gap carrying junk; reload is randomly pulsed and must be ignored.
    task automatic cfg_beat(input logic [DW-1:0] d, input bit last);
        if ($urandom_range(0, 3) == 0) begin
            cfg_valid = 1'b0;
            cfg_data  = DW'($urandom);
            cfg_last  = 1'($urandom);
            tick();
        end
        cfg_valid = 1'b1;
        cfg_data  = d;
        cfg_last  = last;
        reload    = ($urandom_range(0, 7) == 0);
        tick();
        cfg_valid = 1'b0;
        cfg_last  = 1'b0;
        reload    = 1'b0;
        model_tab[mptr] = d;
        if (mptr == DEPTH - 1 && last) mptr = 0;
        else if (mptr == DEPTH - 1 || last) begin
            merr = 1'b1;
            mptr = 0;
        end else mptr++;
    endtask

    // Stream next_tab[first .. first+count-1]; cfg_last set on index last_idx.
    task automatic stream_entries(input int first, input int count, input int last_idx);
        for (int i = first; i < first + count; i++) cfg_beat(next_tab[i], i == last_idx);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cfg_valid = 1'b0; cfg_last = 1'b0; cfg_data = '0; reload = 1'b0;
        data_in_0 = '0; data_in_0_valid = 1'b0; data_out_0_ready = 1'b0;
        tick();
        tick();
        checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL reset_cfg_ready: got %b expected 0", cfg_ready); end
        checks++; if (table_loaded !== 1'b0) begin errors++; $display("FAIL reset_table_loaded: got %b expected 0", table_loaded); end
        checks++; if (data_out_0_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", data_out_0_valid); end
        checks++; if (data_out_0 !== '0) begin errors++; $display("FAIL reset_out_data: got %0h expected 0", data_out_0); end
        checks++; if (cfg_error !== 1'b0) begin errors++; $display("FAIL reset_cfg_error: got %b expected 0", cfg_error); end
        checks++; if (data_in_0_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", data_in_0_ready); end
        rst = 1'b0;
        tick();
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL post_reset_cfg_ready: got %b expected 1", cfg_ready); end
        model_reset();
    endtask

    task automatic test_full_load();
        logic [AW-1:0] idx [4];
        logic [DW-1:0] want [4];
        idx[0] = 6'h05; idx[1] = 6'h20; idx[2] = 6'h2C; idx[3] = 6'h3F;
        want[0] = 6'h03; want[1] = 6'h3F; want[2] = 6'h3E; want[3] = 6'h00;
        fill_next_random();
        next_tab[6'h00] = 6'h00; next_tab[6'h05] = 6'h03; next_tab[6'h20] = 6'h3F;
        next_tab[6'h2C] = 6'h3E; next_tab[6'h3F] = 6'h00;
        stream_entries(0, DEPTH - 1, DEPTH - 1);
        checks++; if (table_loaded !== 1'b0) begin errors++; $display("FAIL load_partial_loaded: got %b expected 0", table_loaded); end
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL load_partial_cfg_ready: got %b expected 1", cfg_ready); end
        cfg_beat(next_tab[DEPTH - 1], 1'b1);
        checks++; if (table_loaded !== 1'b1) begin errors++; $display("FAIL load_done_loaded: got %b expected 1", table_loaded); end
        checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL load_done_cfg_ready: got %b expected 0", cfg_ready); end
        checks++; if (cfg_error !== 1'b0) begin errors++; $display("FAIL load_done_cfg_error: got %b expected 0", cfg_error); end
        data_out_0_ready = 1'b1;
        data_in_0_valid  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            data_in_0 = idx[k];
            #1;
            checks++; if (data_in_0_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready[%0d]: got %b expected 1", k, data_in_0_ready); end
            tick();
            checks++;
            if (data_out_0_valid !== 1'b1 || data_out_0 !== want[k]) begin
                errors++;
                $display("FAIL b2b_lookup[%0h]: got valid=%b data=%0h expected valid=1 data=%0h", idx[k], data_out_0_valid, data_out_0, want[k]);
            end
        end
        data_in_0_valid = 1'b0;
        tick();
        checks++; if (data_out_0_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain_valid: got %b expected 0", data_out_0_valid); end
    endtask

    task automatic test_backpressure();
        data_in_0_valid  = 1'b1;
        data_in_0        = 6'h05;
        data_out_0_ready = 1'b0;
        tick();
        data_in_0 = 6'h2C;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (data_in_0_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b expected 0", k, data_in_0_ready); end
            checks++;
            if (data_out_0_valid !== 1'b1 || data_out_0 !== 6'h03) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got valid=%b data=%0h expected valid=1 data=3", k, data_out_0_valid, data_out_0);
            end
            tick();
        end
        data_out_0_ready = 1'b1;
        data_in_0        = 6'h20;
        #1;
        checks++; if (data_in_0_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b expected 1", data_in_0_ready); end
        tick();
        checks++;
        if (data_out_0_valid !== 1'b1 || data_out_0 !== 6'h3F) begin
            errors++;
            $display("FAIL bp_release_data: got valid=%b data=%0h expected valid=1 data=3f", data_out_0_valid, data_out_0);
        end
        data_in_0_valid = 1'b0;
        tick();
        checks++; if (data_out_0_valid !== 1'b0) begin errors++; $display("FAIL bp_drain_valid: got %b expected 0", data_out_0_valid); end
    endtask

    // Random lookup traffic with random output backpressure, in RUN.
    task automatic test_random_lookups(input int n);
        bit            exp_rdy;
        logic [AW-1:0] a;
        for (int c = 0; c < n; c++) begin
            data_in_0_valid  = ($urandom_range(0, 3) != 0);
            a                = AW'($urandom);
            data_in_0        = a;
            data_out_0_ready = ($urandom_range(0, 3) != 0);
            #1;
            exp_rdy = !exp_vld || data_out_0_ready;
            checks++; if (data_in_0_ready !== exp_rdy) begin errors++; $display("FAIL rnd_in_ready[%0d]: got %b expected %b", c, data_in_0_ready, exp_rdy); end
            tick();
            if (data_in_0_valid && exp_rdy) begin
                exp_vld  = 1'b1;
                exp_data = model_tab[a];
            end else if (exp_vld && data_out_0_ready) begin
                exp_vld = 1'b0;
            end
            checks++;
            if (data_out_0_valid !== exp_vld || (exp_vld && data_out_0 !== exp_data)) begin
                errors++;
                $display("FAIL rnd_out[%0d]: got valid=%b data=%0h expected valid=%b data=%0h", c, data_out_0_valid, data_out_0, exp_vld, exp_data);
            end
        end
        data_in_0_valid  = 1'b0;
        data_out_0_ready = 1'b1;
        tick();
        exp_vld = 1'b0;
        checks++; if (data_out_0_valid !== 1'b0) begin errors++; $display("FAIL rnd_drain_valid: got %b expected 0", data_out_0_valid); end
    endtask

    // Every table entry, in a random order, one lookup per cycle.
    task automatic test_back_to_back();
        int perm [DEPTH];
        int j, t;
        for (int i = 0; i < DEPTH; i++) perm[i] = i;
        for (int i = DEPTH - 1; i > 0; i--) begin
            j = $urandom_range(0, i);
            t = perm[i]; perm[i] = perm[j]; perm[j] = t;
        end
        data_out_0_ready = 1'b1;
        data_in_0_valid  = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            data_in_0 = AW'(perm[k]);
            #1;
            checks++; if (data_in_0_ready !== 1'b1) begin errors++; $display("FAIL sweep_in_ready[%0d]: got %b expected 1", k, data_in_0_ready); end
            tick();
            checks++;
            if (data_out_0_valid !== 1'b1 || data_out_0 !== model_tab[perm[k]]) begin
                errors++;
                $display("FAIL sweep_lookup[%0h]: got valid=%b data=%0h expected valid=1 data=%0h", perm[k], data_out_0_valid, data_out_0, model_tab[perm[k]]);
            end
        end
        data_in_0_valid = 1'b0;
        tick();
        checks++; if (data_out_0_valid !== 1'b0) begin errors++; $display("FAIL sweep_drain_valid: got %b expected 0", data_out_0_valid); end
    endtask

    task automatic test_reload_pending();
        data_in_0_valid  = 1'b1;
        data_in_0        = 6'h05;
        data_out_0_ready = 1'b0;
        tick();
        reload = 1'b1;
        #1;
        checks++; if (data_in_0_ready !== 1'b0) begin errors++; $display("FAIL rl_cycle_in_ready: got %b expected 0", data_in_0_ready); end
        tick();
        reload = 1'b0;
        for (int k = 0; k < 2; k++) begin
            checks++; if (table_loaded !== 1'b0) begin errors++; $display("FAIL rl_drain_loaded[%0d]: got %b expected 0", k, table_loaded); end
            checks++; if (data_in_0_ready !== 1'b0) begin errors++; $display("FAIL rl_drain_in_ready[%0d]: got %b expected 0", k, data_in_0_ready); end
            checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL rl_drain_cfg_ready[%0d]: got %b expected 0", k, cfg_ready); end
            checks++;
            if (data_out_0_valid !== 1'b1 || data_out_0 !== 6'h03) begin
                errors++;
                $display("FAIL rl_drain_hold[%0d]: got valid=%b data=%0h expected valid=1 data=3", k, data_out_0_valid, data_out_0);
            end
            reload = (k == 0);
            tick();
            reload = 1'b0;
        end
        data_out_0_ready = 1'b1;
        tick();
        checks++; if (data_out_0_valid !== 1'b0) begin errors++; $display("FAIL rl_drained_valid: got %b expected 0", data_out_0_valid); end
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL rl_load_cfg_ready: got %b expected 1", cfg_ready); end
        checks++; if (data_in_0_ready !== 1'b0) begin errors++; $display("FAIL rl_load_in_ready: got %b expected 0", data_in_0_ready); end
        data_in_0_valid = 1'b0;
        fill_next_random();
        next_tab[6'h05] = 6'h0A;
        stream_entries(0, DEPTH, DEPTH - 1);
        checks++; if (table_loaded !== 1'b1) begin errors++; $display("FAIL rl_reloaded: got %b expected 1", table_loaded); end
        data_in_0_valid = 1'b1;
        data_in_0       = 6'h05;
        tick();
        checks++;
        if (data_out_0_valid !== 1'b1 || data_out_0 !== 6'h0A) begin
            errors++;
            $display("FAIL rl_new_entry: got valid=%b data=%0h expected valid=1 data=a", data_out_0_valid, data_out_0);
        end
        // Reload while the pending result is consumed in the same cycle.
        data_in_0_valid = 1'b0;
        reload          = 1'b1;
        tick();
        reload = 1'b0;
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL rl_consume_cfg_ready: got %b expected 1", cfg_ready); end
        checks++; if (data_out_0_valid !== 1'b0) begin errors++; $display("FAIL rl_consume_valid: got %b expected 0", data_out_0_valid); end
        fill_next_random();
        stream_entries(0, DEPTH, DEPTH - 1);
        checks++; if (table_loaded !== 1'b1) begin errors++; $display("FAIL rl_consume_reloaded: got %b expected 1", table_loaded); end
    endtask

    task automatic test_early_last();
        reload = 1'b1;
        tick();
        reload = 1'b0;
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL el_idle_reload_cfg_ready: got %b expected 1", cfg_ready); end
        fill_next_random();
        stream_entries(0, 10, 9);
        checks++; if (cfg_error !== merr) begin errors++; $display("FAIL el_cfg_error: got %b expected %b", cfg_error, merr); end
        checks++; if (table_loaded !== 1'b0) begin errors++; $display("FAIL el_loaded: got %b expected 0", table_loaded); end
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL el_cfg_ready: got %b expected 1", cfg_ready); end
        fill_next_random();
        stream_entries(0, DEPTH, DEPTH - 1);
        checks++; if (table_loaded !== 1'b1) begin errors++; $display("FAIL el_reload_loaded: got %b expected 1", table_loaded); end
        checks++; if (cfg_error !== 1'b1) begin errors++; $display("FAIL el_error_sticky: got %b expected 1", cfg_error); end
        test_random_lookups(150);
    endtask

    task automatic test_reset_mid_load();
        data_in_0_valid  = 1'b1;
        data_in_0        = AW'($urandom);
        data_out_0_ready = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        checks++; if (data_out_0_valid !== 1'b0) begin errors++; $display("FAIL rml_lookup_valid: got %b expected 0", data_out_0_valid); end
        checks++; if (data_in_0_ready !== 1'b0) begin errors++; $display("FAIL rml_lookup_in_ready: got %b expected 0", data_in_0_ready); end
        rst = 1'b0;
        data_in_0_valid  = 1'b0;
        data_out_0_ready = 1'b1;
        tick();
        model_reset();
        fill_next_random();
        stream_entries(0, 30, DEPTH - 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (table_loaded !== 1'b0) begin errors++; $display("FAIL rml_loaded: got %b expected 0", table_loaded); end
        checks++; if (data_out_0_valid !== 1'b0) begin errors++; $display("FAIL rml_out_valid: got %b expected 0", data_out_0_valid); end
        checks++; if (cfg_error !== 1'b0) begin errors++; $display("FAIL rml_cfg_error: got %b expected 0", cfg_error); end
        model_reset();
        // Every new value differs from the aborted one at the same address.
        for (int i = 0; i < DEPTH; i++) next_tab[i] = next_tab[i] ^ DW'($urandom_range(1, 63));
        stream_entries(0, DEPTH, DEPTH - 1);
        checks++; if (table_loaded !== 1'b1) begin errors++; $display("FAIL rml_reloaded: got %b expected 1", table_loaded); end
        test_back_to_back();
    endtask

    task automatic test_missing_last();
        reload = 1'b1;
        tick();
        reload = 1'b0;
        fill_next_random();
        stream_entries(0, DEPTH - 1, -1);
        checks++; if (cfg_error !== 1'b0) begin errors++; $display("FAIL ml_error_early: got %b expected 0", cfg_error); end
        cfg_beat(next_tab[DEPTH - 1], 1'b0);
        checks++; if (cfg_error !== 1'b1) begin errors++; $display("FAIL ml_cfg_error: got %b expected 1", cfg_error); end
        checks++; if (table_loaded !== 1'b0) begin errors++; $display("FAIL ml_loaded: got %b expected 0", table_loaded); end
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL ml_cfg_ready: got %b expected 1", cfg_ready); end
        fill_next_random();
        stream_entries(0, DEPTH, DEPTH - 1);
        checks++; if (table_loaded !== 1'b1) begin errors++; $display("FAIL ml_reloaded: got %b expected 1", table_loaded); end
        test_back_to_back();
        test_random_lookups(100);
    endtask

    initial begin
        test_reset();
        test_full_load();
        test_backpressure();
        test_random_lookups(200);
        test_reload_pending();
        test_back_to_back();
        test_early_last();
        test_reset_mid_load();
        test_missing_last();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
